loop_step_counter: RTL



---
 rtl/loop_step_counter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/loop_step_counter.sv
// loop_step_counter
//
// Registered loop/iteration counter that sits beside the ALU. The control
// unit loads a trip count, pulses step once per iteration and branches on
// done. Each step moves the count by STEP, up or down. When a step crosses
// the terminal value, the counter either saturates at that value or wraps
// modulo 2^WIDTH and pulses wrap for one cycle.
//
// Parameters
//   WIDTH       counter/data width in bits (2..32)
//   STEP        magnitude added/subtracted per step, 1 <= STEP < 2^WIDTH
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   clear       synchronous clear to IDLE with count = 0
//   load        load load_value; enter RUN (or DONE if load_value == 0)
//   load_value  initial count
//   step        advance the count by STEP (honoured only in RUN)
//   up          direction, 1 = increment, 0 = decrement
//   sat_mode    1 = saturate at the terminal value, 0 = wrap and pulse wrap
//   count       current count (registered)
//   zero        count == 0 (registered)
//   busy        state is RUN
//   done        state is DONE (level-held until clear/load)
//   wrap        one-cycle pulse after a wrapping step
module loop_step_counter #(
    parameter int          WIDTH = 16,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             step,
    input  logic             up,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             zero_q, zero_d;
    logic             wrap_q, wrap_d;

    // One bit wider than the count, so that the top bit of the difference is
    // the borrow and the top bit of the sum is the carry.
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   sum;
    logic             borrow;
    logic             carry;

    assign diff   = {1'b0, count_q} - {1'b0, STEP_W};
    assign sum    = {1'b0, count_q} + {1'b0, STEP_W};
    assign borrow = diff[WIDTH];
    assign carry  = sum[WIDTH];

    // Next-state logic. Priority is clear > load > step. wrap defaults to 0,
    // so it can only ever be a single-cycle pulse.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wrap_d  = 1'b0;

        if (clear) begin
            state_d = S_IDLE;
            count_d = '0;
        end else if (load) begin
            count_d = load_value;
            // A zero trip count is already finished, whatever the direction.
            state_d = (load_value == '0) ? S_DONE : S_RUN;
        end else if (step && (state_q == S_RUN)) begin
            if (up) begin
                if (carry) begin
                    count_d = sat_mode ? ALL_ONES : sum[WIDTH-1:0];
                    wrap_d  = ~sat_mode;
                    state_d = S_DONE;
                end else begin
                    count_d = sum[WIDTH-1:0];
                    if (sum[WIDTH-1:0] == ALL_ONES) begin
                        state_d = S_DONE;
                    end
                end
            end else begin
                if (borrow) begin
                    count_d = sat_mode ? '0 : diff[WIDTH-1:0];
                    wrap_d  = ~sat_mode;
                    state_d = S_DONE;
                end else begin
                    count_d = diff[WIDTH-1:0];
                    if (diff[WIDTH-1:0] == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
        end
    end

    // zero is registered from the next count, so it tracks count exactly
    // without adding a combinational compare on the output.
    assign zero_d = (count_d == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            zero_q  <= 1'b1;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            zero_q  <= zero_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign zero  = zero_q;
    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_DONE);
    assign wrap  = wrap_q;

endmodule
